// File: rtl/sprite_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sprite_cmd_scheduler
// Purpose  : Queues host sprite-update words in a FIFO and broadcasts them to
//            every sprite display component, stamping bit 13 with the current
//            back-buffer index. Host commit words (action == SWAP_ACTION) are
//            held at the FIFO head until vertical blank, then replaced by one
//            global buffer-swap word, at most once per frame.
// Ports    : clk, reset (async, active-high)
//            host_write/host_writedata/host_ready : host word input
//            hcount/vcount                        : VGA beam position
//            clear_overflow                       : clears sticky overflow
//            cmd_writedata                        : registered broadcast word
//            front_buf, commit_pending, frame_count, overflow : status
// Revision : 1.0 - initial release
// ============================================================================
module sprite_cmd_scheduler #(
  parameter int         FIFO_DEPTH  = 16,
  parameter int         VBLANK_LINE = 480,
  parameter logic [3:0] SWAP_ACTION = 4'hF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        host_write,
  input  logic [31:0] host_writedata,
  output logic        host_ready,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        clear_overflow,
  output logic [31:0] cmd_writedata,
  output logic        front_buf,
  output logic        commit_pending,
  output logic [15:0] frame_count,
  output logic        overflow
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [9:0] VBL     = 10'(VBLANK_LINE);
  localparam logic [AW:0] DEPTH  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_DRAIN    = 2'd0,
    ST_WAIT_VBL = 2'd1,
    ST_SWAP     = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] count;
  logic        full;
  logic        empty;
  logic [31:0] head;
  logic        head_is_commit;
  logic        in_vblank;
  logic        swap_armed;
  logic        push;
  logic        drop;
  logic        pop;

  // Column position is not needed: swaps are gated on whole lines only.
  logic unused_hcount;
  assign unused_hcount = ^hcount;

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count          = wr_ptr - rd_ptr;
  assign full           = (count == DEPTH);
  assign empty          = (wr_ptr == rd_ptr);
  assign host_ready     = ~full;
  assign head           = mem[rd_ptr[AW-1:0]];
  assign head_is_commit = (head[20:17] == SWAP_ACTION);
  assign in_vblank      = (vcount >= VBL);
  assign push           = host_write & ~full;
  assign drop           = host_write & full;

  always_comb begin
    pop = 1'b0;
    case (state)
      ST_DRAIN:    pop = ~empty & ~head_is_commit;
      // The commit itself is consumed when the swap is launched.
      ST_WAIT_VBL: pop = in_vblank & swap_armed;
      default:     pop = 1'b0;
    endcase
  end

  // Storage has no reset: validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= host_writedata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_DRAIN;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      cmd_writedata  <= 32'h0;
      front_buf      <= 1'b0;
      commit_pending <= 1'b0;
      frame_count    <= 16'h0;
      overflow       <= 1'b0;
      swap_armed     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;

      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;

      // Arming happens only outside vblank, so a swap launched inside vblank
      // cannot be followed by a second one until the next frame.
      if (state == ST_WAIT_VBL && pop) swap_armed <= 1'b0;
      else if (!in_vblank)             swap_armed <= 1'b1;

      case (state)
        ST_DRAIN: begin
          if (!empty && !head_is_commit) begin
            cmd_writedata <= {head[31:14], ~front_buf, head[12:0]};
          end else if (!empty) begin
            cmd_writedata  <= 32'h0;
            commit_pending <= 1'b1;
            state          <= ST_WAIT_VBL;
          end else begin
            cmd_writedata <= 32'h0;
          end
        end
        ST_WAIT_VBL: begin
          cmd_writedata <= 32'h0;
          if (in_vblank && swap_armed) begin
            // The swap word is registered here so it is on the bus during
            // the SWAP cycle; its bit 13 names the buffer now being shown.
            cmd_writedata  <= {11'b0, SWAP_ACTION, 3'b0, ~front_buf, 13'b0};
            front_buf      <= ~front_buf;
            frame_count    <= frame_count + 16'd1;
            commit_pending <= 1'b0;
            state          <= ST_SWAP;
          end
        end
        ST_SWAP: begin
          cmd_writedata <= 32'h0;
          state         <= ST_DRAIN;
        end
        default: begin
          cmd_writedata <= 32'h0;
          state         <= ST_DRAIN;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sprite_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_cmd_scheduler
// Purpose  : Directed self-checking bench for sprite_cmd_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_cmd_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        host_write;
  logic [31:0] host_writedata;
  logic        host_ready;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        clear_overflow;
  logic [31:0] cmd_writedata;
  logic        front_buf;
  logic        commit_pending;
  logic [15:0] frame_count;
  logic        overflow;

  int checks = 0;
  int fails  = 0;

  localparam logic [31:0] COMMIT = 32'h001E0000;
  localparam logic [31:0] SWAP1  = 32'h001E2000;
  localparam logic [31:0] SWAP0  = 32'h001E0000;

  always #5 clk = ~clk;

  sprite_cmd_scheduler #(
    .FIFO_DEPTH (16),
    .VBLANK_LINE(480),
    .SWAP_ACTION(4'hF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .host_write    (host_write),
    .host_writedata(host_writedata),
    .host_ready    (host_ready),
    .hcount        (hcount),
    .vcount        (vcount),
    .clear_overflow(clear_overflow),
    .cmd_writedata (cmd_writedata),
    .front_buf     (front_buf),
    .commit_pending(commit_pending),
    .frame_count   (frame_count),
    .overflow      (overflow)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; host_write = 1'b0; host_writedata = 32'h0;
    clear_overflow = 1'b0; hcount = 10'd0; vcount = 10'd100;
    tick; tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic push(input logic [31:0] w);
    host_write = 1'b1; host_writedata = w;
    tick;
    host_write = 1'b0;
  endtask

  // Advances until the bus carries a non-idle word, bounded to 64 cycles.
  task automatic wait_bus(output bit ok);
    int n = 0;
    while (cmd_writedata === 32'h0 && n < 64) begin
      tick;
      n++;
    end
    ok = (cmd_writedata !== 32'h0);
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (cmd_writedata !== 32'h0) begin fails++; $display("FAIL reset_cmd: got %h expected %h", cmd_writedata, 32'h0); end
    checks++; if (front_buf !== 1'b0) begin fails++; $display("FAIL reset_front: got %b expected 0", front_buf); end
    checks++; if (frame_count !== 16'h0) begin fails++; $display("FAIL reset_frame: got %h expected 0000", frame_count); end
    checks++; if (host_ready !== 1'b1 || overflow !== 1'b0 || commit_pending !== 1'b0) begin
      fails++; $display("FAIL reset_flags: got ready=%b ovf=%b pend=%b expected 1 0 0", host_ready, overflow, commit_pending);
    end
  endtask

  task automatic test_single;
    do_reset;
    push(32'h20022005);
    checks++; if (cmd_writedata !== 32'h0) begin fails++; $display("FAIL single_early: got %h expected %h", cmd_writedata, 32'h0); end
    tick;
    checks++; if (cmd_writedata !== 32'h20022005) begin fails++; $display("FAIL single_word: got %h expected %h", cmd_writedata, 32'h20022005); end
    tick;
    checks++; if (cmd_writedata !== 32'h0) begin fails++; $display("FAIL single_pulse: got %h expected %h", cmd_writedata, 32'h0); end
    push(32'h20020007);
    tick;
    checks++; if (cmd_writedata !== 32'h20022007) begin fails++; $display("FAIL single_bit13_set: got %h expected %h", cmd_writedata, 32'h20022007); end
  endtask

  task automatic test_back_to_back;
    do_reset;
    push(32'h04020001);
    push(32'h08043FFF);
    checks++; if (cmd_writedata !== 32'h04022001) begin fails++; $display("FAIL b2b_first: got %h expected %h", cmd_writedata, 32'h04022001); end
    tick;
    checks++; if (cmd_writedata !== 32'h08043FFF) begin fails++; $display("FAIL b2b_second: got %h expected %h", cmd_writedata, 32'h08043FFF); end
    tick;
    checks++; if (cmd_writedata !== 32'h0) begin fails++; $display("FAIL b2b_idle: got %h expected %h", cmd_writedata, 32'h0); end
  endtask

  task automatic test_commit;
    bit ok;
    int bad = 0;
    do_reset;
    vcount = 10'd200;
    push(COMMIT);
    push(32'h0C022011);
    push(32'h0C020012);
    push(32'h0C046013);
    checks++; if (commit_pending !== 1'b1) begin fails++; $display("FAIL commit_pending: got %b expected 1", commit_pending); end
    for (int i = 0; i < 5; i++) begin
      if (cmd_writedata !== 32'h0) bad++;
      tick;
    end
    checks++; if (bad != 0) begin fails++; $display("FAIL commit_hold: got %0d busy cycles expected 0", bad); end
    vcount = 10'd480;
    wait_bus(ok);
    checks++; if (!ok || cmd_writedata !== SWAP1) begin fails++; $display("FAIL commit_swap_word: got %h expected %h", cmd_writedata, SWAP1); end
    tick;
    checks++; if (cmd_writedata !== 32'h0) begin fails++; $display("FAIL commit_swap_once: got %h expected %h", cmd_writedata, 32'h0); end
    checks++; if (front_buf !== 1'b1 || frame_count !== 16'd1 || commit_pending !== 1'b0) begin
      fails++; $display("FAIL commit_status: got front=%b frame=%h pend=%b expected 1 0001 0", front_buf, frame_count, commit_pending);
    end
    wait_bus(ok);
    checks++; if (!ok || cmd_writedata !== 32'h0C020011) begin fails++; $display("FAIL commit_drain_a: got %h expected %h", cmd_writedata, 32'h0C020011); end
    tick;
    checks++; if (cmd_writedata !== 32'h0C020012) begin fails++; $display("FAIL commit_drain_b: got %h expected %h", cmd_writedata, 32'h0C020012); end
    tick;
    checks++; if (cmd_writedata !== 32'h0C044013) begin fails++; $display("FAIL commit_drain_c: got %h expected %h", cmd_writedata, 32'h0C044013); end
    tick;
    checks++; if (cmd_writedata !== 32'h0) begin fails++; $display("FAIL commit_drain_end: got %h expected %h", cmd_writedata, 32'h0); end
  endtask

  task automatic test_two_commits;
    bit ok;
    int bad = 0;
    do_reset;
    vcount = 10'd300;
    push(COMMIT);
    push(COMMIT);
    tick;
    vcount = 10'd480;
    wait_bus(ok);
    checks++; if (!ok || cmd_writedata !== SWAP1) begin fails++; $display("FAIL two_first_swap: got %h expected %h", cmd_writedata, SWAP1); end
    tick;
    for (int i = 0; i < 6; i++) begin
      if (cmd_writedata !== 32'h0) bad++;
      tick;
    end
    checks++; if (bad != 0 || commit_pending !== 1'b1 || frame_count !== 16'd1) begin
      fails++; $display("FAIL two_second_held: got busy=%0d pend=%b frame=%h expected 0 1 0001", bad, commit_pending, frame_count);
    end
    vcount = 10'd0;
    tick;
    vcount = 10'd480;
    wait_bus(ok);
    checks++; if (!ok || cmd_writedata !== SWAP0) begin fails++; $display("FAIL two_second_swap: got %h expected %h", cmd_writedata, SWAP0); end
    tick;
    checks++; if (frame_count !== 16'd2 || front_buf !== 1'b0) begin
      fails++; $display("FAIL two_status: got frame=%h front=%b expected 0002 0", frame_count, front_buf);
    end
  endtask

  task automatic test_overflow;
    bit ok;
    do_reset;
    vcount = 10'd200;
    push(COMMIT);
    for (int i = 0; i < 15; i++) push(32'h10020000 + 32'(i));
    checks++; if (host_ready !== 1'b0 || overflow !== 1'b0) begin
      fails++; $display("FAIL ovf_full: got ready=%b ovf=%b expected 0 0", host_ready, overflow);
    end
    push(32'h10020055);
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    host_write = 1'b1; host_writedata = 32'h10020066; clear_overflow = 1'b1;
    tick;
    host_write = 1'b0;
    checks++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set_wins: got %b expected 1", overflow); end
    tick;
    clear_overflow = 1'b0;
    checks++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
    vcount = 10'd480;
    wait_bus(ok);
    checks++; if (!ok || cmd_writedata !== SWAP1) begin fails++; $display("FAIL ovf_swap: got %h expected %h", cmd_writedata, SWAP1); end
    tick;
    wait_bus(ok);
    checks++; if (!ok || cmd_writedata !== 32'h10020000) begin fails++; $display("FAIL ovf_first_drain: got %h expected %h", cmd_writedata, 32'h10020000); end
  endtask

  task automatic test_wrap;
    bit ok;
    do_reset;
    force dut.frame_count = 16'hFFFF;
    tick;
    release dut.frame_count;
    checks++; if (frame_count !== 16'hFFFF) begin fails++; $display("FAIL wrap_preload: got %h expected ffff", frame_count); end
    push(COMMIT);
    vcount = 10'd480;
    wait_bus(ok);
    tick;
    checks++; if (!ok || frame_count !== 16'h0 || front_buf !== 1'b1) begin
      fail_wrap(ok);
    end
  endtask

  task automatic fail_wrap(input bit ok);
    fails++;
    $display("FAIL wrap_swap: got seen=%b frame=%h front=%b expected 1 0000 1", ok, frame_count, front_buf);
  endtask

  task automatic test_reset_midswap;
    bit ok;
    int bad = 0;
    do_reset;
    push(COMMIT);
    for (int i = 0; i < 5; i++) push(32'h18020100 + 32'(i));
    vcount = 10'd480;
    wait_bus(ok);
    checks++; if (!ok || cmd_writedata !== SWAP1) begin fails++; $display("FAIL midswap_reach: got %h expected %h", cmd_writedata, SWAP1); end
    reset = 1'b1;
    #1;
    checks++; if (cmd_writedata !== 32'h0 || front_buf !== 1'b0 || frame_count !== 16'h0 || host_ready !== 1'b1) begin
      fails++; $display("FAIL midswap_reset: got cmd=%h front=%b frame=%h ready=%b expected 0 0 0000 1", cmd_writedata, front_buf, frame_count, host_ready);
    end
    tick;
    reset = 1'b0;
    vcount = 10'd100;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (cmd_writedata !== 32'h0) bad++;
    end
    checks++; if (bad != 0 || commit_pending !== 1'b0) begin
      fails++; $display("FAIL midswap_flushed: got busy=%0d pend=%b expected 0 0", bad, commit_pending);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_commit;
    test_two_commits;
    test_overflow;
    checks++;
    test_wrap;
    test_reset_midswap;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_cmd_scheduler.md
Name: sprite_cmd_scheduler

Overview:
- Sits between the Avalon host write port and the broadcast writedata bus that feeds every sprite display component (Fireball, Mario, blocks, ...).
- Queues host sprite-update words in a FIFO and stamps each one with the current back-buffer index.
- Issues the global buffer-swap word (action 4'hF) only during vertical blank, at most once per frame, so no component flips its ping/pong buffer mid-scan.

Parameters:
FIFO_DEPTH, 16, number of queued 32-bit command words (power of 2)
VBLANK_LINE, 480, first vcount value treated as vertical blank
SWAP_ACTION, 4'hF, action code marking a host commit / emitted swap

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
host_write  input  1  host word valid this cycle
host_writedata  input  32  host command {component[31:26], rsvd[25:21], action[20:17], type[16:14], toggle[13], data[12:0]}
host_ready  output  1  FIFO not full (combinational from occupancy)
hcount  input  10  current VGA column
vcount  input  10  current VGA line
clear_overflow  input  1  clears the sticky overflow flag
cmd_writedata  output  32  registered broadcast word to all display components; 32'h0 when idle
front_buf  output  1  buffer index components currently display
commit_pending  output  1  commit is at FIFO head, waiting for vblank
frame_count  output  16  swaps issued, wraps 16'hFFFF->0
overflow  output  1  sticky: a host write was dropped because the FIFO was full

Behaviour:
- Reset (async): FIFO empty, state DRAIN, cmd_writedata=0, front_buf=0, commit_pending=0, frame_count=0, overflow=0, swap_armed=0, host_ready=1. A reset mid-operation discards all queued words and returns the bus to 0 on the next cycle.
- Push: host_write && !full -> word enters FIFO. host_write && full -> word dropped, overflow<=1. Push and pop in the same cycle are allowed, and occupancy stays unchanged. clear_overflow with a simultaneous drop -> overflow stays 1 (set wins).
- Host bit 13 is ignored. The scheduler replaces it on output.
- swap_armed <= 1 whenever vcount < VBLANK_LINE. It is cleared when a swap is issued. in_vblank = (vcount >= VBLANK_LINE).
- State DRAIN: if the FIFO is non-empty and the head action != SWAP_ACTION, pop the head and present it on cmd_writedata for exactly one cycle, with bit13 = ~front_buf. Throughput is one word per cycle. If the head is a commit, do not pop: go to WAIT_VBL and set commit_pending=1. If the FIFO is empty, cmd_writedata=0.
- State WAIT_VBL: cmd_writedata=0 and nothing is popped. Words pushed behind the commit stay queued. When in_vblank && swap_armed: pop the commit and go to SWAP.
- State SWAP (one cycle):
  - cmd_writedata = {6'b0, 5'b0, SWAP_ACTION, 3'b0, ~front_buf, 13'b0}.
  - front_buf <= ~front_buf; frame_count <= frame_count+1; swap_armed<=0; commit_pending<=0.
  - Next state DRAIN. The swap word lasts one cycle; the following cycle is never a repeat of it.
- Latency: a word captured at edge E into an empty FIFO in DRAIN appears on cmd_writedata after edge E+1 and is held one cycle.
- Two commits in one frame: the second waits in WAIT_VBL until the next frame's vblank (swap_armed rearms only after vcount < VBLANK_LINE).
- A commit reaching the head while already inside vblank with swap_armed=1 swaps immediately (WAIT_VBL lasts one cycle).
- Every non-idle word is a single-cycle pulse, because components act on every cycle the word is present.

Test Plan:
- Reset mid-SWAP with 5 words queued -> cmd_writedata=0, front_buf=0, frame_count=0, host_ready=1, queued words gone.
- vcount=100, push 32'h20022005 (Fireball, action 1, type 0, X pos 5) -> after two edges cmd_writedata=32'h20022005 with bit13 set (front_buf=0 -> back=1), for one cycle, then 32'h0.
- Push commit 32'h001E0000 at vcount=200, then push 3 updates -> commit_pending=1, bus 0 until vcount=480. Then one cycle of 32'h001E2000, front_buf=1, frame_count=1. Then the 3 updates drain with bit13=0.
- Two commits pushed at vcount=300 -> first swap at vcount=480, second only at the next frame's vcount=480; frame_count=2 total.
- Write 17 words while WAIT_VBL blocks draining -> host_ready=0 after 16, 17th dropped, overflow=1. clear_overflow -> 0.
- frame_count preloaded to 16'hFFFF via 65535 commits (or force) -> next swap gives frame_count=0, front_buf toggles.
